// File: rtl/microsequencer.sv
// Microprogram next-state controller: picks the next ROM address and
// keeps a small return stack for microsubroutines.
module microsequencer #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ST    = 0,
  parameter int FETCH_ST    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    n,
  input  logic          inv,
  input  logic          mi,
  input  logic [2:0]    s,
  input  logic [AW-1:0] cr,
  input  logic [AW-1:0] enc_addr,
  input  logic [7:0]    cond,
  input  logic          moc,
  output logic [AW-1:0] state,
  output logic          hold,
  output logic          stack_err
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam logic [SW-1:0] FULL = SW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    N_DISP  = 3'b000,
    N_FETCH = 3'b001,
    N_JUMP  = 3'b010,
    N_CBR   = 3'b011,
    N_WAIT  = 3'b100,
    N_CALL  = 3'b101,
    N_RET   = 3'b110,
    N_CDISP = 3'b111
  } ntype_t;

  ntype_t        nt;
  logic          c;
  logic          stall;
  logic [AW-1:0] inc;
  logic [AW-1:0] nxt;
  logic [SW-1:0] sp;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] top;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          err_set;
  logic          whold;

  logic [AW-1:0] stk [STACK_DEPTH];

  assign nt     = ntype_t'(n);
  assign c      = cond[s] ^ inv;
  assign stall  = mi & ~moc;
  assign inc    = state + AW'(1);
  assign empty  = (sp == '0);
  assign full   = (sp == FULL);
  assign wr_idx = sp[IW-1:0];
  // When full, sp[IW-1:0] wraps to 0, so subtracting 1 still lands on the top
  assign rd_idx = sp[IW-1:0] - IW'(1);
  assign top    = stk[rd_idx];

  always_comb begin
    nxt     = state;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    whold   = 1'b0;
    if (!stall) begin
      unique case (nt)
        N_DISP:  nxt = enc_addr;
        N_FETCH: nxt = AW'(FETCH_ST);
        N_JUMP:  nxt = cr;
        N_CBR:   nxt = c ? cr : inc;
        N_WAIT: begin
          whold = c;
          nxt   = c ? state : inc;
        end
        N_CALL: begin
          nxt = cr;
          if (full) err_set = 1'b1;
          else      push    = 1'b1;
        end
        N_RET: begin
          if (empty) begin
            nxt     = AW'(FETCH_ST);
            err_set = 1'b1;
          end else begin
            nxt = top;
            pop = 1'b1;
          end
        end
        N_CDISP: nxt = c ? enc_addr : cr;
      endcase
    end
  end

  assign hold = rst_n & (stall | whold);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= AW'(RESET_ST);
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= nxt;
      if (push)     sp <= sp + SW'(1);
      else if (pop) sp <= sp - SW'(1);
      if (err_set)  stack_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) stk[wr_idx] <= inc;
  end

endmodule
